// File: rtl/lim_mem_responder.sv
// Word-addressed logic-in-memory responder with optional racetrack shift latency.
// Define LIM_SHIFT_LATENCY_EN to model access-port movement; otherwise every access takes one cycle.
module lim_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_SIZE   = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_ab_i,
  input  logic [ADDR_WIDTH-1:0] ADDR_i,
  input  logic [3:0]            be_b_i,
  input  logic                  write_en_data_i,
  input  logic [31:0]           write_i_data_i,
  input  logic [31:0]           mask_i,
  input  logic [2:0]            logic_in_memory_funct_int_i,
  output logic [31:0]           r_data_o,
  output logic                  r_valid_o,
  output logic                  busy_o
);
  localparam int WORDS = MAX_SIZE / 4;
  localparam int IW    = ADDR_WIDTH - 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] tgt;
  logic [3:0]    be_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mask_q;
  logic [2:0]    funct_q;
  logic [31:0]   mem [WORDS];

  logic [IW-1:0] req_idx;
  logic          need_shift;
  logic          unused_addr_lsb;

  assign req_idx         = ADDR_i[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^ADDR_i[1:0];
  assign busy_o          = (state != ST_IDLE);

`ifdef LIM_SHIFT_LATENCY_EN
  logic [IW-1:0] pos;
  logic [IW-1:0] pos_nxt;
  assign need_shift = (req_idx != pos);
  assign pos_nxt    = (tgt > pos) ? pos + 1'b1 : pos - 1'b1;
`else
  assign need_shift = 1'b0;
`endif

  // Operation datapath, evaluated against the captured request
  logic          in_range;
  logic          lim;
  logic [31:0]   cur;
  logic [31:0]   lane;
  logic [31:0]   lim_val;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [31:0]   resp;

  always_comb begin
    in_range = (int'(tgt) < WORDS);
    cur      = in_range ? mem[tgt] : 32'h0;
    lane     = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    lim      = ~funct_q[2] & (|funct_q[1:0]);
    case (funct_q[1:0])
      2'b01:   lim_val = cur ^ mask_q;
      2'b10:   lim_val = cur & mask_q;
      2'b11:   lim_val = cur | mask_q;
      default: lim_val = cur;
    endcase
    wr_word = (cur & ~lane) | ((lim ? lim_val : wdata_q) & lane);
    rd_word = (lim ? lim_val : cur) & lane;
    // An all-disabled request answers zero even for writes
    if (be_q == 4'b0000) resp = 32'h0;
    else                 resp = we_q ? wr_word : rd_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      tgt       <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      mask_q    <= '0;
      funct_q   <= '0;
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
`ifdef LIM_SHIFT_LATENCY_EN
      pos       <= '0;
`endif
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      r_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_ab_i) begin
            tgt     <= req_idx;
            be_q    <= be_b_i;
            we_q    <= write_en_data_i;
            wdata_q <= write_i_data_i;
            mask_q  <= mask_i;
            funct_q <= logic_in_memory_funct_int_i;
            state   <= need_shift ? ST_SHIFT : ST_ACCESS;
          end
        end
`ifdef LIM_SHIFT_LATENCY_EN
        ST_SHIFT: begin
          pos <= pos_nxt;
          if (pos_nxt == tgt) state <= ST_ACCESS;
        end
`endif
        ST_ACCESS: begin
          if (we_q && in_range) mem[tgt] <= wr_word;
          r_data_o  <= resp;
          r_valid_o <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lim_mem_responder.sv
// Randomized self-checking bench for lim_mem_responder against a byte-lane memory model.
// Expected latency follows LIM_SHIFT_LATENCY_EN the same way the design build does.
module tb_lim_mem_responder;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_ab_i;
  logic [7:0]  ADDR_i;
  logic [3:0]  be_b_i;
  logic        write_en_data_i;
  logic [31:0] write_i_data_i;
  logic [31:0] mask_i;
  logic [2:0]  logic_in_memory_funct_int_i;
  logic [31:0] r_data_o;
  logic        r_valid_o;
  logic        busy_o;

  lim_mem_responder #(.ADDR_WIDTH(8), .MAX_SIZE(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_ab_i(en_ab_i), .ADDR_i(ADDR_i),
    .be_b_i(be_b_i), .write_en_data_i(write_en_data_i),
    .write_i_data_i(write_i_data_i), .mask_i(mask_i),
    .logic_in_memory_funct_int_i(logic_in_memory_funct_int_i),
    .r_data_o(r_data_o), .r_valid_o(r_valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] mm [64];
  int          pos_m;
  logic [31:0] last_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mm[i] = 32'h0;
    pos_m  = 0;
    last_r = 32'h0;
  endtask

  task automatic req(input logic [7:0] addr, input logic [3:0] be, input bit we,
                     input logic [31:0] wd, input logic [31:0] mk, input logic [2:0] f,
                     input bit b2b, input bit stray);
    int          idx, d, lat;
    bit          seen;
    logic [31:0] cur, post, rd, exp;
    logic [7:0]  b, v;
    // Reference: operate lane by lane on the addressed word
    idx  = int'(addr[7:2]);
    cur  = mm[idx];
    post = cur;
    rd   = 32'h0;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) begin
        b = cur[8*n +: 8];
        case (f)
          3'd1:    v = b ^ mk[8*n +: 8];
          3'd2:    v = b & mk[8*n +: 8];
          3'd3:    v = b | mk[8*n +: 8];
          default: v = we ? wd[8*n +: 8] : b;
        endcase
        post[8*n +: 8] = v;
        rd[8*n +: 8]   = v;
      end
    end
    exp = (be == 4'b0) ? 32'h0 : (we ? post : rd);
    if (we) mm[idx] = post;
`ifdef LIM_SHIFT_LATENCY_EN
    d = (idx > pos_m) ? idx - pos_m : pos_m - idx;
    pos_m = idx;
`else
    d = 0;
`endif

    if (!b2b) begin
      @(negedge clk_i);
      chk("vld_low", 32'(r_valid_o), 32'h0);
      chk("rdata_hold", r_data_o, last_r);
    end
    ADDR_i = addr; be_b_i = be; write_en_data_i = we; write_i_data_i = wd;
    mask_i = mk; logic_in_memory_funct_int_i = f; en_ab_i = 1'b1;
    @(posedge clk_i); #1 en_ab_i = 1'b0;
    @(negedge clk_i);
    chk("busy", 32'(busy_o), 32'h1);
    if (stray) begin
      ADDR_i = 8'($urandom); be_b_i = 4'hF; write_en_data_i = 1'b1;
      write_i_data_i = $urandom; logic_in_memory_funct_int_i = 3'd0; en_ab_i = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    while (lat < 200) begin
      @(posedge clk_i); lat++; #1 en_ab_i = 1'b0;
      @(negedge clk_i);
      if (r_valid_o) begin seen = 1'b1; break; end
    end
    chk("valid_seen", 32'(seen), 32'h1);
    chk("latency", 32'(lat), 32'(d + 1));
    chk("rdata", r_data_o, exp);
    last_r = exp;
  endtask

  initial begin
    logic [5:0] ri;
    bit         no_pulse;
    rst_i = 1'b1; en_ab_i = 1'b0; ADDR_i = '0; be_b_i = '0; write_en_data_i = 1'b0;
    write_i_data_i = '0; mask_i = '0; logic_in_memory_funct_int_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_valid", 32'(r_valid_o), 32'h0);
    chk("rst_rdata", r_data_o, 32'h0);
    rst_i = 1'b0;

    // Directed vectors
    req(8'h04, 4'hF, 1, 32'h0000349B, 0, 3'd0, 0, 0);
    req(8'h04, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    chk("std_read", r_data_o, 32'h0000349B);
    req(8'h04, 4'hF, 1, 32'h0000349B, 0, 3'd0, 0, 0);
    req(8'h04, 4'hF, 1, 0, 32'hF1, 3'd3, 0, 0);
    chk("lim_or", r_data_o, 32'h000034FB);
    req(8'h04, 4'hF, 1, 32'h0000349B, 0, 3'd0, 0, 0);
    req(8'h04, 4'hF, 1, 0, 32'h8D, 3'd2, 0, 0);
    chk("lim_and", r_data_o, 32'h00000089);
    req(8'h04, 4'hF, 1, 32'h0000349B, 0, 3'd0, 0, 0);
    req(8'h04, 4'hF, 1, 0, 32'h71, 3'd1, 0, 0);
    chk("lim_xor", r_data_o, 32'h000034EA);
    req(8'h04, 4'hF, 1, 32'h0000349B, 0, 3'd0, 0, 0);
    req(8'h04, 4'h1, 1, 0, 32'h8D, 3'd2, 0, 0);
    chk("lim_and_be1", r_data_o, 32'h00003489);
    req(8'h04, 4'hF, 1, 32'h0000349B, 0, 3'd0, 0, 0);
    req(8'h04, 4'h1, 0, 0, 0, 3'd0, 0, 0);
    chk("read_be1", r_data_o, 32'h0000009B);
    req(8'h04, 4'hF, 0, 0, 32'h0F, 3'd5, 0, 0);
    req(8'h04, 4'h0, 1, 32'hDEADBEEF, 0, 3'd0, 0, 0);
    req(8'h04, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    // Shift distances, back-to-back acceptance and ignored strobes
    req(8'h00, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    req(8'h10, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    req(8'h08, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    req(8'h20, 4'hF, 1, 32'hA5A5_0101, 0, 3'd0, 0, 1);
    req(8'h21, 4'hF, 0, 0, 0, 3'd0, 1, 0);
    req(8'h0C, 4'h6, 1, 32'h1234_5678, 0, 3'd0, 1, 1);

    for (int i = 0; i < 150; i++) begin
      ri = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      req({ri, 2'($urandom)}, 4'($urandom), 1'($urandom), $urandom, $urandom,
          3'($urandom_range(0, 7)), ($urandom % 4) == 0, ($urandom % 4) == 0);
    end

    // Abort a pending write to word 4 with reset
    req(8'h00, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    @(negedge clk_i);
    ADDR_i = 8'h10; be_b_i = 4'hF; write_en_data_i = 1'b1; write_i_data_i = 32'hCAFEF00D;
    logic_in_memory_funct_int_i = 3'd0; en_ab_i = 1'b1;
    @(posedge clk_i); #1 en_ab_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    no_pulse = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (r_valid_o) no_pulse = 1'b0;
    end
    chk("abort_no_pulse", 32'(no_pulse), 32'h1);
    chk("abort_busy_low", 32'(busy_o), 32'h0);
    chk("abort_rdata", r_data_o, 32'h0);
    model_reset();
    req(8'h10, 4'hF, 0, 0, 0, 3'd0, 0, 0);
    chk("abort_word4", r_data_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lim_mem_responder.md
LIM_MEM_RESPONDER -- requirements
Module: lim_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: byte-address width.
REQ-002 SHALL have parameter MAX_SIZE, default 256: memory size in bytes; word count is MAX_SIZE/4.
REQ-003 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1: synchronous, active-high reset.
REQ-005 SHALL have port en_ab_i  input  1: request strobe, sampled only in IDLE.
REQ-006 SHALL have port ADDR_i  input  ADDR_WIDTH: byte address; word index = ADDR_i[ADDR_WIDTH-1:2], bits [1:0] ignored.
REQ-007 SHALL have port be_b_i  input  4: byte-lane enables, bit n = bits [8n+7:8n].
REQ-008 SHALL have port write_en_data_i  input  1: 1 = write request, 0 = read request.
REQ-009 SHALL have port write_i_data_i  input  32: write data for standard writes.
REQ-010 SHALL have port mask_i  input  32: logic-in-memory operand.
REQ-011 SHALL have port logic_in_memory_funct_int_i  input  3: 000 standard, 001 XOR, 010 AND, 011 OR; 1xx treated as 000.
REQ-012 SHALL have port r_data_o  output  32: response data.
REQ-013 SHALL have port r_valid_o  output  1: one-cycle response pulse.
REQ-014 SHALL have port busy_o  output  1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, ACCESS.
REQ-016 In IDLE with en_ab_i=1, SHALL capture address, be, write_en, data, mask and opcode at the edge.
REQ-016a At that capture edge SHALL compute d = |captured word index - pos| and go to SHIFT if d>0, else to ACCESS.
REQ-017 SHALL hold a position register pos (word index, reset 0) modelling the racetrack access port.
REQ-017a In SHIFT SHALL move pos one step toward the target per cycle, entering ACCESS on the edge pos reaches target.
REQ-018 In ACCESS SHALL perform the operation, register r_data_o, pulse r_valid_o high for exactly the next cycle, and return to IDLE.
REQ-018a Latency from capture edge to r_valid_o high SHALL be d+1 cycles.
REQ-019 SHALL ignore en_ab_i while busy_o=1; no queuing.
REQ-019a A request SHALL be accepted in the same cycle r_valid_o is high, since the FSM is already in IDLE.
REQ-020 Standard write SHALL update enabled lanes with write_i_data_i; disabled lanes keep their value.
REQ-020a For a LiM write, each enabled lane SHALL become mem OP mask_i; disabled lanes are unchanged.
REQ-021 Standard read SHALL return mem in enabled lanes and 0 in disabled lanes.
REQ-021a LiM read SHALL return (mem OP mask_i) in enabled lanes and 0 in disabled lanes; memory unchanged.
REQ-022 On writes, r_data_o SHALL equal the full post-write 32-bit word; r_valid_o still pulses.
REQ-023 be_b_i=0000 SHALL leave memory unchanged, return r_data_o=0 and still pulse r_valid_o.
REQ-024 r_data_o SHALL hold its last value until the next ACCESS.

Reset
REQ-025 rst_i=1 at a rising edge SHALL force state IDLE, pos=0, r_valid_o=0, r_data_o=0, busy_o=0, and all memory words=0.
REQ-026 Reset asserted mid-operation (SHIFT or ACCESS) SHALL abort it: no memory update and no r_valid_o pulse.

Configuration
REQ-027 With macro LIM_SHIFT_LATENCY_EN defined, SHALL model shift latency per REQ-016a/017.
REQ-028 Without LIM_SHIFT_LATENCY_EN, d SHALL be forced to 0: every request goes IDLE->ACCESS, latency 1, pos stays 0.

Verification
REQ-029 Standard write 0x0000349B to ADDR 0x04 (be 1111), then standard read of 0x04 -> r_data_o=0x0000349B.
REQ-030 LiM writes to word 0x04=0x0000349B, each from that initial value -> stored/returned word as below:
- OR with mask 0xF1 -> 0x000034FB.
- AND with mask 0x8D -> 0x00000089.
- XOR with mask 0x71 -> 0x000034EA.
REQ-031 Word 0x04=0x0000349B:
- LiM AND write, be 0001, mask 0x8D -> word 0x00003489.
- Standard read, be 0001 -> r_data_o=0x0000009B.
REQ-032 Macro on, pos=0: request ADDR 0x10 -> r_valid_o high exactly 5 cycles after capture, pos=4.
- Then request ADDR 0x08 -> latency 3.
REQ-033 Reset during SHIFT of a write to 0x10 -> no r_valid_o pulse, word 4 reads 0, pos=0.
REQ-034 Second en_ab_i pulse while busy_o=1 -> ignored; exactly one r_valid_o pulse per accepted request.
